aes128_sequencer: RTL and testbench
===================================

# aes128_sequencer

Control sequencer for the iterative AES-128 datapath behind the TinyQV peripheral register file. Accepts the CTRL start pulse and operation code, then drives the datapath's load, round-step, key-schedule and capture strobes through initial key addition, all rounds and result capture. Maintains the ready/done/error status bits and the peripheral interrupt. Sits between the register block and the round/key datapath; it holds no data, only control state.

## Interface
- NUM_ROUNDS, default 10: AES rounds per block; round index width is 4 bits.
- ROUND_CYCLES, default 1, legal range 1–15: datapath cycles per round (>1 when the S-box is time-shared).
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- start_i  in  1  single-cycle start pulse from CTRL bit 0.
- op_i  in  2  operation: 2'b00 encrypt, 2'b01 decrypt, others invalid. Sampled only with start_i.
- irq_en_i  in  1  interrupt enable (CTRL bit 3).
- abort_i  in  1  cancel the current run.
- done_clr_i  in  1  clear done_o and error_o (status read/acknowledge).
- ready_o  out  1  idle and able to accept start.
- done_o  out  1  sticky; the last run completed.
- error_o  out  1  sticky; the last start carried an invalid op.
- irq_o  out  1  interrupt level.
- load_o  out  1  load state = data XOR round key.
- round_en_o  out  1  datapath commits one round.
- key_step_o  out  1  forward key-schedule step (decrypt pre-expansion).
- round_o  out  4  current round-key index.
- last_round_o  out  1  final round (omit MixColumns).
- decrypt_o  out  1  latched operation; held for the whole run.
- capture_o  out  1  latch the datapath state into RESULT0–3.

## Operation
- States: IDLE, KEYX, LOAD, ROUND, FIN.
- IDLE: ready_o=1. On start_i:
  - Valid op: latch decrypt_o, clear done_o. Encrypt → LOAD with round_o=0. Decrypt → KEYX with round_o=0.
  - Invalid op: set error_o, clear done_o, stay in IDLE.
- KEYX: key_step_o=1 every cycle, round_o increments once per cycle. After NUM_ROUNDS cycles (round_o=NUM_ROUNDS) → LOAD. Cycle count is independent of ROUND_CYCLES.
- LOAD: load_o=1 for exactly one cycle, then → ROUND.
  - Encrypt: round_o=0 during LOAD, then steps to 1.
  - Decrypt: round_o=NUM_ROUNDS during LOAD, then steps to NUM_ROUNDS-1.
- ROUND: a sub-counter cycles 0..ROUND_CYCLES-1.
  - round_en_o=1 only when the sub-counter is at ROUND_CYCLES-1.
  - On that cycle, round_o steps: +1 for encrypt, -1 for decrypt.
  - last_round_o=1 while round_o=NUM_ROUNDS (encrypt) or round_o=0 (decrypt).
  - round_en_o on the last round → FIN.
- FIN: capture_o=1 for one cycle, then → IDLE; done_o set on that transition.
- irq_o = done_o AND irq_en_i, both registered; no combinational path from start_i.
- abort_i in any non-IDLE state: → IDLE next cycle. No capture, done_o not set, error_o unchanged. abort_i in IDLE has no effect.
- Simultaneous events:
  - FIN and done_clr_i in the same cycle: the set wins.
  - start_i and done_clr_i in the same cycle: done_o clears, error_o follows the start rule.
  - start_i outside IDLE: ignored, no status change.
- Strobes (load_o, round_en_o, key_step_o, capture_o) are mutually exclusive and all 0 in IDLE.

## Timing
- Reset values: state IDLE, ready_o=1, all other outputs 0 (including round_o=0 and decrypt_o=0).
- All outputs are registered or decoded from registered state only.
- start_i high in cycle 0, encrypt:
  - LOAD in cycle 1.
  - ROUND in cycles 2 .. 1+NUM_ROUNDS·ROUND_CYCLES.
  - FIN in the next cycle.
  - done_o high in cycle 3+NUM_ROUNDS·ROUND_CYCLES; for defaults, LOAD at 1, ROUND at 2–11, FIN at 12, done_o at 13.
- Decrypt adds NUM_ROUNDS KEYX cycles; for defaults, done_o is high in cycle 23.
- ready_o falls in cycle 1 and returns in the same cycle done_o rises.
- A new start_i is accepted in the first cycle ready_o=1.

## Configuration
- AES128_SEQ_DECRYPT_EN defined: behaviour exactly as above.
- AES128_SEQ_DECRYPT_EN undefined:
  - KEYX state and key_step_o logic removed; key_step_o and decrypt_o tied to 0.
  - op 2'b01 is treated as invalid and sets error_o.

## Structure
- aes128_pkg holds:
  - the state enum (IDLE/KEYX/LOAD/ROUND/FIN);
  - op encodings AES_OP_ENC=2'b00 and AES_OP_DEC=2'b01;
  - AES128_NUM_ROUNDS=10.
- One sub-module, aes128_round_counter, holds the round and sub-cycle counters with load/up/down control and terminal-count flags. The FSM and status bits stay in aes128_sequencer.

## Test plan
- Encrypt, defaults: start with op=00 at cycle 0.
  - load_o at 1; round_en_o at 2–11 with round_o 1..10; last_round_o only at 11.
  - capture_o at 12; done_o=1 and ready_o=1 at 13.
  - irq_o=1 at 13 when irq_en_i=1; irq_o stays 0 when irq_en_i=0.
- Decrypt, defaults: start with op=01.
  - key_step_o at cycles 1–10; load_o at 11 with round_o=10.
  - Rounds 9..0 at 12–21, with last_round_o at 21.
  - capture_o at 22; done_o at 23.
  - Without the macro: error_o=1, no strobes.
- ROUND_CYCLES=3, encrypt: round_en_o every 3rd cycle, 10 pulses total, done_o at cycle 33.
- Invalid op (2'b11): error_o=1, ready_o stays 1, no strobes. done_clr_i clears error_o next cycle.
- Abort at round 5: state is IDLE the next cycle, no capture_o, done_o=0. A following start completes normally.
- Corner cases:
  - start_i while busy: no effect.
  - done_clr_i coinciding with FIN: done_o=1.
  - rst asserted mid-ROUND: all outputs return to reset values immediately, asynchronously.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 control sequencer.
// Decrypt support is enabled by defining AES128_SEQ_DECRYPT_EN.
package aes128_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEYX  = 3'd1,
        LOAD  = 3'd2,
        ROUND = 3'd3,
        FIN   = 3'd4
    } aes_state_e;

    localparam logic [1:0] AES_OP_ENC = 2'b00;
    localparam logic [1:0] AES_OP_DEC = 2'b01;

    localparam int AES128_NUM_ROUNDS = 10;

    // Without decrypt support only encrypt is a legal operation
    function automatic logic aes_op_valid(input logic [1:0] op);
`ifdef AES128_SEQ_DECRYPT_EN
        return (op == AES_OP_ENC) || (op == AES_OP_DEC);
`else
        return (op == AES_OP_ENC);
`endif
    endfunction

endpackage

// File: rtl/aes128_round_counter.sv
// Round-key index and per-round sub-cycle counters for the AES-128 sequencer.
// Clear has priority; round steps up or down, sub-counter wraps at ROUND_CYCLES-1.
module aes128_round_counter #(
    parameter int NUM_ROUNDS   = 10,
    parameter int ROUND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    input  logic       sub_en,
    output logic [3:0] round,
    output logic       sub_tc,
    output logic       at_zero,
    output logic       at_max
);

    logic [3:0] round_r;
    logic [3:0] sub_r;

    // Round index and sub-cycle counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_r <= 4'd0;
            sub_r   <= 4'd0;
        end else if (clr) begin
            round_r <= 4'd0;
            sub_r   <= 4'd0;
        end else begin
            if (inc) begin
                round_r <= round_r + 4'd1;
            end else if (dec) begin
                round_r <= round_r - 4'd1;
            end else begin
                round_r <= round_r;
            end
            if (sub_en) begin
                sub_r <= sub_tc ? 4'd0 : (sub_r + 4'd1);
            end else begin
                sub_r <= sub_r;
            end
        end
    end

    assign round   = round_r;
    assign sub_tc  = (sub_r == 4'(ROUND_CYCLES - 1));
    assign at_zero = (round_r == 4'd0);
    assign at_max  = (round_r == 4'(NUM_ROUNDS));

endmodule

// File: rtl/aes128_sequencer.sv
// Control FSM and status bits for the iterative AES-128 datapath.
// Decrypt (KEYX pre-expansion) is present only when AES128_SEQ_DECRYPT_EN is defined.
module aes128_sequencer
    import aes128_pkg::*;
#(
    parameter int NUM_ROUNDS   = AES128_NUM_ROUNDS,
    parameter int ROUND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [1:0] op_i,
    input  logic       irq_en_i,
    input  logic       abort_i,
    input  logic       done_clr_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       error_o,
    output logic       irq_o,
    output logic       load_o,
    output logic       round_en_o,
    output logic       key_step_o,
    output logic [3:0] round_o,
    output logic       last_round_o,
    output logic       decrypt_o,
    output logic       capture_o
);

    aes_state_e state_r, state_d_s;
    logic       done_r, error_r, irq_r;
    logic       done_d_s, error_d_s;
    logic       decrypt_s;
    logic       start_ok_s, start_bad_s;
    logic       cnt_clr_s, cnt_inc_s, cnt_dec_s, sub_en_s;
    logic       sub_tc_s, at_zero_s, at_max_s, last_s;

    aes128_round_counter #(
        .NUM_ROUNDS  (NUM_ROUNDS),
        .ROUND_CYCLES(ROUND_CYCLES)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .inc    (cnt_inc_s),
        .dec    (cnt_dec_s),
        .sub_en (sub_en_s),
        .round  (round_o),
        .sub_tc (sub_tc_s),
        .at_zero(at_zero_s),
        .at_max (at_max_s)
    );

`ifdef AES128_SEQ_DECRYPT_EN
    logic decrypt_r;

    // Operation latched on an accepted start and held for the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decrypt_r <= 1'b0;
        end else if (start_ok_s) begin
            decrypt_r <= (op_i == AES_OP_DEC);
        end else begin
            decrypt_r <= decrypt_r;
        end
    end

    assign decrypt_s  = decrypt_r;
    assign key_step_o = (state_r == KEYX);
`else
    assign decrypt_s  = 1'b0;
    assign key_step_o = 1'b0;
`endif

    // Decrypt counts rounds down to key 0, encrypt up to key NUM_ROUNDS
    assign last_s = decrypt_s ? at_zero_s : at_max_s;

    // Next-state and counter control
    always_comb begin
        state_d_s   = state_r;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        cnt_dec_s   = 1'b0;
        sub_en_s    = 1'b0;
        start_ok_s  = 1'b0;
        start_bad_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (aes_op_valid(op_i)) begin
                        start_ok_s = 1'b1;
                        cnt_clr_s  = 1'b1;
`ifdef AES128_SEQ_DECRYPT_EN
                        state_d_s  = (op_i == AES_OP_DEC) ? KEYX : LOAD;
`else
                        state_d_s  = LOAD;
`endif
                    end else begin
                        start_bad_s = 1'b1;
                    end
                end else begin
                    state_d_s = IDLE;
                end
            end
`ifdef AES128_SEQ_DECRYPT_EN
            KEYX: begin
                if (abort_i) begin
                    state_d_s = IDLE;
                end else begin
                    cnt_inc_s = 1'b1;
                    state_d_s = (round_o == 4'(NUM_ROUNDS - 1)) ? LOAD : KEYX;
                end
            end
`endif
            LOAD: begin
                if (abort_i) begin
                    state_d_s = IDLE;
                end else begin
                    state_d_s = ROUND;
                    cnt_inc_s = ~decrypt_s;
                    cnt_dec_s = decrypt_s;
                end
            end
            ROUND: begin
                if (abort_i) begin
                    state_d_s = IDLE;
                end else begin
                    sub_en_s = 1'b1;
                    if (sub_tc_s && last_s) begin
                        state_d_s = FIN;
                    end else if (sub_tc_s) begin
                        cnt_inc_s = ~decrypt_s;
                        cnt_dec_s = decrypt_s;
                    end else begin
                        state_d_s = ROUND;
                    end
                end
            end
            FIN: begin
                state_d_s = IDLE;
            end
            default: begin
                state_d_s = IDLE;
            end
        endcase
    end

    // Sticky status: completion set beats acknowledge, any start re-evaluates error
    always_comb begin
        done_d_s  = done_r;
        error_d_s = error_r;
        if ((state_r == FIN) && !abort_i) begin
            done_d_s = 1'b1;
        end else if (done_clr_i || start_ok_s || start_bad_s) begin
            done_d_s = 1'b0;
        end else begin
            done_d_s = done_r;
        end
        if (start_ok_s || start_bad_s) begin
            error_d_s = start_bad_s;
        end else if (done_clr_i) begin
            error_d_s = 1'b0;
        end else begin
            error_d_s = error_r;
        end
    end

    // State and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_d_s;
            done_r  <= done_d_s;
            error_r <= error_d_s;
            irq_r   <= done_d_s & irq_en_i;
        end
    end

    assign ready_o      = (state_r == IDLE);
    assign load_o       = (state_r == LOAD);
    assign round_en_o   = (state_r == ROUND) && sub_tc_s;
    assign last_round_o = (state_r == ROUND) && last_s;
    assign capture_o    = (state_r == FIN);
    assign decrypt_o    = decrypt_s;
    assign done_o       = done_r;
    assign error_o      = error_r;
    assign irq_o        = irq_r;

endmodule

// File: tb/tb_aes128_sequencer.sv
// Scoreboard bench for aes128_sequencer: expected strobe/done events are queued
// at stimulus time and popped by a monitor on the falling clock edge.
module tb_aes128_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0, start3 = 1'b0;
    logic [1:0] op_i = 2'b00;
    logic       irq_en_i = 1'b0, abort_i = 1'b0, done_clr_i = 1'b0;
    logic       ready_o, done_o, error_o, irq_o, load_o, round_en_o, key_step_o;
    logic       last_round_o, decrypt_o, capture_o;
    logic [3:0] round_o;
    logic       ready3, done3, error3, irq3, load3, round_en3, key_step3;
    logic       last3, decrypt3, capture3;
    logic [3:0] round3;

    int cyc = 0;
    int nchecks = 0;
    int nfail = 0;
    logic done_prev = 1'b0, done3_prev = 1'b0;

    typedef struct {int cyc; int kind; int rnd; bit last;} ev_t;
    ev_t q[$];
    int  q3[$];
    int  done3_exp = -1;

    aes128_sequencer dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .irq_en_i(irq_en_i),
        .abort_i(abort_i), .done_clr_i(done_clr_i), .ready_o(ready_o), .done_o(done_o),
        .error_o(error_o), .irq_o(irq_o), .load_o(load_o), .round_en_o(round_en_o),
        .key_step_o(key_step_o), .round_o(round_o), .last_round_o(last_round_o),
        .decrypt_o(decrypt_o), .capture_o(capture_o)
    );

    aes128_sequencer #(.ROUND_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start_i(start3), .op_i(op_i), .irq_en_i(irq_en_i),
        .abort_i(abort_i), .done_clr_i(done_clr_i), .ready_o(ready3), .done_o(done3),
        .error_o(error3), .irq_o(irq3), .load_o(load3), .round_en_o(round_en3),
        .key_step_o(key_step3), .round_o(round3), .last_round_o(last3),
        .decrypt_o(decrypt3), .capture_o(capture3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // kind: 1 load, 2 round_en, 3 key_step, 4 capture, 5 done rising
    task automatic ev(input int kind);
        ev_t e;
        bit  ok;
        nchecks++;
        if (q.size() == 0) begin
            nfail++;
            $display("FAIL unexpected_event cycle=%0d kind=%0d round=%0d", cyc, kind, round_o);
        end else begin
            e  = q.pop_front();
            ok = (e.cyc == cyc) && (e.kind == kind) &&
                 (kind > 3 || (e.rnd == int'(round_o) && e.last == last_round_o));
            if (!ok) begin
                nfail++;
                $display("FAIL event actual cyc=%0d kind=%0d rnd=%0d last=%0d expected cyc=%0d kind=%0d rnd=%0d last=%0d",
                         cyc, kind, round_o, last_round_o, e.cyc, e.kind, e.rnd, e.last);
            end
        end
    endtask

    // Monitor for the default instance
    always @(negedge clk) begin
        if (!rst) begin
            if (load_o || round_en_o || key_step_o || capture_o)
                chk("strobe_excl", int'(load_o) + int'(round_en_o) + int'(key_step_o) + int'(capture_o), 1);
            if (load_o)          ev(1);
            else if (round_en_o) ev(2);
            else if (key_step_o) ev(3);
            else if (capture_o)  ev(4);
            if (done_o && !done_prev) ev(5);
        end
        done_prev <= done_o;
    end

    // Monitor for the ROUND_CYCLES=3 instance
    always @(negedge clk) begin
        if (!rst) begin
            if (round_en3) begin
                if (q3.size() == 0) chk("rc3_extra_pulse", cyc, -1);
                else chk("rc3_pulse_cycle", cyc, q3.pop_front());
            end
            if (done3 && !done3_prev) chk("rc3_done_cycle", cyc, done3_exp);
        end
        done3_prev <= done3;
    end

    // mode: 0 encrypt, 1 encrypt aborted after round 5, 2 decrypt, 3 no events expected
    task automatic issue(input logic [1:0] op, input int mode, output int base);
        @(negedge clk);
        base = cyc;
        if (mode == 0 || mode == 1) begin
            q.push_back('{base + 1, 1, 0, 1'b0});
            for (int r = 1; r <= ((mode == 1) ? 5 : 10); r++)
                q.push_back('{base + 1 + r, 2, r, (r == 10)});
            if (mode == 0) begin
                q.push_back('{base + 12, 4, 0, 1'b0});
                q.push_back('{base + 13, 5, 0, 1'b0});
            end
        end
`ifdef AES128_SEQ_DECRYPT_EN
        if (mode == 2) begin
            for (int k = 1; k <= 10; k++) q.push_back('{base + k, 3, k - 1, 1'b0});
            q.push_back('{base + 11, 1, 10, 1'b0});
            for (int j = 1; j <= 10; j++) q.push_back('{base + 11 + j, 2, 10 - j, (j == 10)});
            q.push_back('{base + 22, 4, 0, 1'b0});
            q.push_back('{base + 23, 5, 0, 1'b0});
        end
`endif
        start_i = 1'b1;
        op_i    = op;
        @(negedge clk);
        start_i = 1'b0;
        op_i    = 2'b00;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done_o && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done_o, 1);
    endtask

    task automatic drained(input string name);
        @(negedge clk);
        chk(name, q.size(), 0);
    endtask

    task automatic pulse_clr();
        done_clr_i = 1'b1;
        @(negedge clk);
        done_clr_i = 1'b0;
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_round", round_o, 0);
        chk("rst_decrypt", decrypt_o, 0);

        // Encrypt with interrupt enabled
        irq_en_i = 1'b1;
        issue(2'b00, 0, base);
        chk("busy_ready", ready_o, 0);
        wait_done(40);
        chk("enc_done_cycle", cyc, base + 13);
        chk("enc_ready", ready_o, 1);
        chk("enc_irq", irq_o, 1);
        drained("enc_drained");
        pulse_clr();
        chk("clr_done", done_o, 0);
        chk("clr_irq", irq_o, 0);

        // Encrypt with interrupt disabled
        irq_en_i = 1'b0;
        issue(2'b00, 0, base);
        wait_done(40);
        chk("noirq_irq", irq_o, 0);
        drained("noirq_drained");

        // Decrypt
        issue(2'b01, 2, base);
`ifdef AES128_SEQ_DECRYPT_EN
        wait_done(60);
        chk("dec_done_cycle", cyc, base + 23);
        chk("dec_decrypt", decrypt_o, 1);
        chk("dec_error", error_o, 0);
`else
        repeat (3) @(negedge clk);
        chk("dec_off_error", error_o, 1);
        chk("dec_off_ready", ready_o, 1);
        chk("dec_off_decrypt", decrypt_o, 0);
        pulse_clr();
`endif
        drained("dec_drained");

        // Invalid op
        issue(2'b11, 3, base);
        chk("inv_error", error_o, 1);
        chk("inv_ready", ready_o, 1);
        chk("inv_done", done_o, 0);
        done_clr_i = 1'b1;
        @(negedge clk);
        done_clr_i = 1'b0;
        chk("inv_clr_error", error_o, 0);
        drained("inv_drained");

        // Abort during round 5, then a normal run
        issue(2'b00, 1, base);
        repeat (5) @(negedge clk);
        chk("abort_round", round_o, 5);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_ready", ready_o, 1);
        chk("abort_done", done_o, 0);
        repeat (3) @(negedge clk);
        chk("abort_drained", q.size(), 0);
        issue(2'b00, 0, base);
        wait_done(40);
        chk("after_abort_cycle", cyc, base + 13);
        drained("after_abort_drained");

        // Start while busy is ignored
        issue(2'b00, 0, base);
        repeat (3) @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'b11;
        @(negedge clk);
        start_i = 1'b0;
        op_i    = 2'b00;
        wait_done(40);
        chk("busy_start_error", error_o, 0);
        chk("busy_start_cycle", cyc, base + 13);
        drained("busy_drained");

        // Acknowledge coinciding with FIN: set wins
        issue(2'b00, 0, base);
        repeat (11) @(negedge clk);
        chk("finclr_capture", capture_o, 1);
        done_clr_i = 1'b1;
        @(negedge clk);
        done_clr_i = 1'b0;
        chk("finclr_done", done_o, 1);
        drained("finclr_drained");

        // ROUND_CYCLES=3 instance
        @(negedge clk);
        base = cyc;
        for (int r = 1; r <= 10; r++) q3.push_back(base + 1 + 3 * r);
        done3_exp = base + 33;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (34) @(negedge clk);
        chk("rc3_done", done3, 1);
        chk("rc3_pulses_left", q3.size(), 0);

        // Asynchronous reset mid-ROUND
        issue(2'b00, 0, base);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", ready_o, 1);
        chk("arst_round", round_o, 0);
        chk("arst_round_en", round_en_o, 0);
        chk("arst_done", done_o, 0);
        chk("arst_last", last_round_o, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_idle_ready", ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
